// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, execute redirect and the decode valid/ready stream.
// The fetch unit uses the master modport; memory and decode sit on the slave side.
interface ifetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr, out_pc, out_pcplus4
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr, out_pc, out_pcplus4
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: owns the fetch PC, keeps one memory read in flight and buffers DEPTH {pc, instr} pairs.
// Optional macro IFQ_BYPASS_EN forwards an ack straight to out_* while the queue is empty.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic            CLK,
    input logic            RST,
    ifetch_queue_if.master bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fpc;
    logic [31:0]   fpc_nxt;
    logic [31:0]   pend_addr;
    logic [31:0]   pend_nxt;
    logic          req_q;
    logic          req_nxt;
    logic          drop_q;
    logic          drop_nxt;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];

    logic          ack_v;
    logic          outstanding_nxt;
    logic          push_word;
    logic          do_push;
    logic          pop;
    logic          issue;
    logic          queue_valid;
    logic          byp_valid;
    logic          byp_take;
    logic [31:0]   out_pc_w;
    logic          unused_rpc_bits;

    assign unused_rpc_bits = ^bus.redirect_pc[1:0];

    // An ack only counts while our own request is pending; stale acks after reset fall out here.
    assign ack_v           = req_q & bus.imem_ack;
    assign outstanding_nxt = req_q & ~bus.imem_ack;
    assign push_word       = ack_v & ~drop_q & ~bus.redirect;
    assign queue_valid     = (count != '0);

`ifdef IFQ_BYPASS_EN
    assign byp_valid = push_word & ~queue_valid;
`else
    assign byp_valid = 1'b0;
`endif

    assign byp_take = byp_valid & bus.out_ready;
    assign pop      = queue_valid & bus.out_ready;
    assign do_push  = push_word & ~byp_take;

    // While a request is pending the address comes from pend_addr, so a redirect cannot disturb it.
    assign bus.imem_req  = outstanding_nxt;
    assign bus.imem_addr = req_q ? pend_addr : fpc;

    assign out_pc_w        = byp_valid ? fpc : q_pc[head];
    assign bus.out_valid   = queue_valid | byp_valid;
    assign bus.out_pc      = out_pc_w;
    assign bus.out_instr   = byp_valid ? bus.imem_rdata : q_instr[head];
    assign bus.out_pcplus4 = out_pc_w + 32'd4;

    // Next occupancy, fetch PC and drop flag; a new request is only issued when the post-update
    // occupancy leaves a free slot, which reserves room for the word that request will return.
    always_comb begin
        count_nxt = count;
        fpc_nxt   = fpc;
        drop_nxt  = drop_q;
        if (bus.redirect) begin
            count_nxt = '0;
            fpc_nxt   = {bus.redirect_pc[31:2], 2'b00};
            drop_nxt  = outstanding_nxt;
        end else begin
            count_nxt = count + (AW+1)'(do_push) - (AW+1)'(pop);
            if (push_word) begin
                fpc_nxt = fpc + 32'd4;
            end
            if (ack_v) begin
                drop_nxt = 1'b0;
            end
        end
        issue    = ~outstanding_nxt & (count_nxt < DEPTH_C) & ~bus.redirect;
        req_nxt  = outstanding_nxt | issue;
        pend_nxt = issue ? fpc_nxt : pend_addr;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc       <= START_PC;
            pend_addr <= START_PC;
            req_q     <= 1'b0;
            drop_q    <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            fpc       <= fpc_nxt;
            pend_addr <= pend_nxt;
            req_q     <= req_nxt;
            drop_q    <= drop_nxt;
            count     <= count_nxt;
            if (bus.redirect) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (do_push) begin
                    q_pc[tail]    <= fpc;
                    q_instr[tail] <= bus.imem_rdata;
                    tail          <= tail + AW'(1);
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
            end
        end
    end
endmodule
